// File: rtl/div_pkg.sv
// Shared definitions for the divider launch/capture stage: state encoding,
// default sizing and the operand magnitude helper.
package div_pkg;

    localparam int N_DEF      = 32;
    localparam int SETTLE_DEF = 4;
    localparam int ABS_W      = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Caller sign-extends signed operands to ABS_W, so the top bit is the sign.
    function automatic logic [ABS_W-1:0] abs_n(input logic [ABS_W-1:0] value,
                                               input logic             signed_en);
        logic [ABS_W-1:0] mag;
        if (signed_en && value[ABS_W-1]) begin
            mag = {ABS_W{1'b0}} - value;
        end else begin
            mag = value;
        end
        return mag;
    endfunction

endpackage

// File: rtl/ArrayDivider.sv
// Combinational unsigned restoring array divider; timed as a multicycle path
// by the surrounding sequencer.
module ArrayDivider #(
    parameter int N = 32
) (
    input  logic [N-1:0] Dividend,
    input  logic [N-1:0] Divisor,
    output logic [N-1:0] Quotient
);

    logic [N:0]   rem_s;
    logic [N-1:0] quo_s;

    // One restoring subtract row per quotient bit, MSB first
    always_comb begin
        rem_s = {(N+1){1'b0}};
        quo_s = {N{1'b0}};
        for (int i = N - 1; i >= 0; i--) begin
            rem_s = {rem_s[N-1:0], Dividend[i]};
            if (rem_s >= {1'b0, Divisor}) begin
                rem_s    = rem_s - {1'b0, Divisor};
                quo_s[i] = 1'b1;
            end else begin
                quo_s[i] = 1'b0;
            end
        end
    end

    assign Quotient = quo_s;

endmodule

// File: rtl/div_sequencer.sv
// Launch/capture stage around ArrayDivider: registers operand magnitudes, holds
// them for SETTLE cycles, then captures a sign- and zero-corrected quotient.
module div_sequencer #(
    parameter int N      = div_pkg::N_DEF,
    parameter int SETTLE = div_pkg::SETTLE_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_signed,
    input  logic [N-1:0] Dividend,
    input  logic [N-1:0] Divisor,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] Quotient,
    output logic         div_zero
);

    // The SETTLE parameter shadows the state label, so that one stays qualified.
    import div_pkg::state_t;
    import div_pkg::IDLE;
    import div_pkg::DONE;
    import div_pkg::ABS_W;
    import div_pkg::abs_n;

    localparam int CW = 4;

    state_t           state_r;
    state_t           state_nx_s;
    logic [CW-1:0]    cnt_r;
    logic [N-1:0]     dvd_r;
    logic [N-1:0]     dvs_r;
    logic [N-1:0]     quo_r;
    logic [N-1:0]     arr_q_s;
    logic             neg_r;
    logic             zflag_r;
    logic             dz_r;
    logic [ABS_W-1:0] dvd_ext_s;
    logic [ABS_W-1:0] dvs_ext_s;

    assign dvd_ext_s = in_signed ? {{(ABS_W-N){Dividend[N-1]}}, Dividend}
                                 : {{(ABS_W-N){1'b0}}, Dividend};
    assign dvs_ext_s = in_signed ? {{(ABS_W-N){Divisor[N-1]}}, Divisor}
                                 : {{(ABS_W-N){1'b0}}, Divisor};

    ArrayDivider #(.N(N)) u_array (
        .Dividend (dvd_r),
        .Divisor  (dvs_r),
        .Quotient (arr_q_s)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) state_nx_s = div_pkg::SETTLE;
                else          state_nx_s = IDLE;
            end
            div_pkg::SETTLE: begin
                if (cnt_r == {CW{1'b0}}) state_nx_s = DONE;
                else                     state_nx_s = div_pkg::SETTLE;
            end
            DONE: begin
                if (out_ready) state_nx_s = IDLE;
                else           state_nx_s = DONE;
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // Handshake decodes from registered state only
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_r)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // Operand launch, settle countdown and corrected quotient capture
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r   <= {CW{1'b0}};
            dvd_r   <= {N{1'b0}};
            dvs_r   <= {N{1'b0}};
            neg_r   <= 1'b0;
            zflag_r <= 1'b0;
            quo_r   <= {N{1'b0}};
            dz_r    <= 1'b0;
        end else if (state_r == IDLE && in_valid) begin
            dvd_r   <= N'(abs_n(dvd_ext_s, in_signed));
            dvs_r   <= N'(abs_n(dvs_ext_s, in_signed));
            neg_r   <= in_signed & (Dividend[N-1] ^ Divisor[N-1]);
            zflag_r <= (Divisor == {N{1'b0}});
            cnt_r   <= CW'(SETTLE - 1);
        end else if (state_r == div_pkg::SETTLE) begin
            if (cnt_r == {CW{1'b0}}) begin
                quo_r <= zflag_r ? {N{1'b1}}
                       : (neg_r ? ({N{1'b0}} - arr_q_s) : arr_q_s);
                dz_r  <= zflag_r;
            end else begin
                cnt_r <= cnt_r - 4'd1;
            end
        end
    end

    assign Quotient = quo_r;
    assign div_zero = dz_r;

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench: three div_sequencer instances (SETTLE 4, 1, 15) checked
// every cycle against a transaction-level model using plain integer division.
module tb_div_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst [3];
    logic        iv  [3];
    logic        is  [3];
    logic        orr [3];
    logic [31:0] dd  [3];
    logic [31:0] ds  [3];
    logic        ir  [3];
    logic        ov  [3];
    logic        dz  [3];
    logic [31:0] q   [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        div_sequencer #(.N(32), .SETTLE((g == 0) ? 4 : ((g == 1) ? 1 : 15))) u_dut (
            .clk       (clk),
            .reset     (rst[g]),
            .in_valid  (iv[g]),
            .in_ready  (ir[g]),
            .in_signed (is[g]),
            .Dividend  (dd[g]),
            .Divisor   (ds[g]),
            .out_valid (ov[g]),
            .out_ready (orr[g]),
            .Quotient  (q[g]),
            .div_zero  (dz[g])
        );
    end

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int settle_of(input int g);
        return (g == 0) ? 4 : ((g == 1) ? 1 : 15);
    endfunction

    // Reference result {div_zero, Quotient} from plain integer arithmetic
    function automatic logic [32:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic sg);
        longint sa, sb, qq;
        if (b == 32'd0) return {1'b1, 32'hFFFF_FFFF};
        if (sg) begin
            sa = longint'(signed'(a));
            sb = longint'(signed'(b));
            qq = sa / sb;
            return {1'b0, qq[31:0]};
        end
        return {1'b0, a / b};
    endfunction

    task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model state per instance
    bit          pend     [3];
    bit          known    [3];
    bit          b2b      [3];
    int          acc_at   [3];
    int          last_acc [3];
    logic [32:0] res      [3];
    logic [32:0] exp_out  [3];

    initial begin
        int  s;
        bit  eov;
        forever begin
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                s = settle_of(g);
                if (pend[g] && cyc == acc_at[g] + s) exp_out[g] = res[g];
                eov = pend[g] && (cyc >= acc_at[g] + s);
                if (known[g]) begin
                    chk($sformatf("in_ready[%0d]", g), 33'(ir[g]), 33'(!pend[g]));
                    chk($sformatf("out_valid[%0d]", g), 33'(ov[g]), 33'(eov));
                    chk($sformatf("result[%0d]", g), {dz[g], q[g]}, exp_out[g]);
                end
                if (rst[g]) begin
                    pend[g]     = 1'b0;
                    exp_out[g]  = 33'd0;
                    known[g]    = 1'b1;
                    last_acc[g] = -1;
                end else if (known[g]) begin
                    if (eov && orr[g]) begin
                        pend[g] = 1'b0;
                    end else if (!pend[g] && iv[g]) begin
                        if (b2b[g] && last_acc[g] >= 0)
                            chk($sformatf("spacing[%0d]", g), 33'(cyc + 1 - last_acc[g]),
                                33'(s + 2));
                        pend[g]     = 1'b1;
                        acc_at[g]   = cyc + 1;
                        last_acc[g] = cyc + 1;
                        res[g]      = ref_div(dd[g], ds[g], is[g]);
                    end
                end
            end
        end
    end

    task automatic xact(input int g, input logic [31:0] a, input logic [31:0] b,
                        input logic sg, input int hold,
                        output logic [31:0] rq, output logic rdz, output int lat);
        int n;
        @(posedge clk); #1;
        dd[g] = a; ds[g] = b; is[g] = sg; iv[g] = 1'b1; orr[g] = (hold == 0);
        n = 0;
        @(negedge clk);
        while (!ir[g] && n < 50) begin @(negedge clk); n++; end
        chk("accept_wait", 33'(ir[g]), 33'd1);
        @(posedge clk); #1;
        iv[g] = 1'b0; dd[g] = $urandom; ds[g] = $urandom; is[g] = 1'($urandom_range(0, 1));
        lat = 0;
        while (lat < 100) begin
            @(negedge clk); lat++;
            if (ov[g]) break;
        end
        chk("result_wait", 33'(ov[g]), 33'd1);
        rq = q[g]; rdz = dz[g];
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            iv[g] = 1'b1; dd[g] = 32'd77; ds[g] = 32'd7;
            @(negedge clk);
            chk("bp out_valid", 33'(ov[g]), 33'd1);
            chk("bp in_ready", 33'(ir[g]), 33'd0);
            chk("bp quotient", {dz[g], q[g]}, {rdz, rq});
        end
        if (hold > 0) begin
            @(posedge clk); #1;
            iv[g] = 1'b0; orr[g] = 1'b1;
        end
        @(posedge clk); #1;
    endtask

    task automatic directed();
        logic [31:0] rq;
        logic        rdz;
        int          lat;
        xact(0, 32'd100, 32'd7, 1'b0, 0, rq, rdz, lat);
        chk("100/7", {rdz, rq}, {1'b0, 32'd14});
        chk("latency", 33'(lat), 33'd5);
        xact(0, 32'hFFFF_FF9C, 32'd7, 1'b1, 0, rq, rdz, lat);
        chk("-100/7", {rdz, rq}, {1'b0, 32'hFFFF_FFF2});
        xact(0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, rq, rdz, lat);
        chk("min/-1", {rdz, rq}, {1'b0, 32'h8000_0000});
        xact(0, 32'd1234, 32'd0, 1'b0, 0, rq, rdz, lat);
        chk("1234/0", {rdz, rq}, {1'b1, 32'hFFFF_FFFF});
        xact(0, 32'd10, 32'd5, 1'b0, 0, rq, rdz, lat);
        chk("10/5", {rdz, rq}, {1'b0, 32'd2});
        xact(0, 32'd50, 32'd5, 1'b0, 6, rq, rdz, lat);
        chk("50/5 bp", {rdz, rq}, {1'b0, 32'd10});
        // Reset two cycles into the settle window
        @(posedge clk); #1;
        dd[0] = 32'd1000; ds[0] = 32'd10; is[0] = 1'b0; iv[0] = 1'b1;
        @(negedge clk);
        chk("pre-reset in_ready", 33'(ir[0]), 33'd1);
        @(posedge clk); #1; iv[0] = 1'b0;
        @(posedge clk); #1; rst[0] = 1'b1;
        @(posedge clk); #1; rst[0] = 1'b0;
        @(negedge clk);
        chk("post-reset out_valid", 33'(ov[0]), 33'd0);
        chk("post-reset result", {dz[0], q[0]}, 33'd0);
        chk("post-reset in_ready", 33'(ir[0]), 33'd1);
        xact(0, 32'd9, 32'd3, 1'b0, 0, rq, rdz, lat);
        chk("9/3", {rdz, rq}, {1'b0, 32'd3});
    endtask

    task automatic rnd_ops(input int g);
        case ($urandom_range(0, 7))
            0: begin dd[g] = $urandom; ds[g] = 32'd0; end
            1: begin dd[g] = 32'h8000_0000; ds[g] = 32'hFFFF_FFFF; end
            2: begin dd[g] = $urandom; ds[g] = $urandom_range(1, 9); end
            3: begin dd[g] = $urandom_range(0, 100); ds[g] = $urandom; end
            default: begin dd[g] = $urandom; ds[g] = $urandom; end
        endcase
        is[g] = 1'($urandom_range(0, 1));
    endtask

    task automatic stream(input int g, input int count);
        int done_n;
        int guard;
        bit acc;
        done_n = 0; guard = 0;
        @(posedge clk); #1;
        orr[g] = 1'b1; b2b[g] = 1'b1; rnd_ops(g); iv[g] = 1'b1;
        while (done_n < count && guard < count * 40) begin
            @(negedge clk); acc = ir[g];
            @(posedge clk); #1; guard++;
            if (acc) begin done_n++; rnd_ops(g); end
        end
        iv[g] = 1'b0; b2b[g] = 1'b0;
        chk($sformatf("stream_count[%0d]", g), 33'(done_n), 33'(count));
        guard = 0;
        @(negedge clk);
        while (!ir[g] && guard < 50) begin @(negedge clk); guard++; end
        chk($sformatf("drain[%0d]", g), 33'(ir[g]), 33'd1);
    endtask

    initial begin
        for (int g = 0; g < 3; g++) begin
            rst[g] = 1'b1; iv[g] = 1'b0; is[g] = 1'b0; orr[g] = 1'b0;
            dd[g] = 32'd0; ds[g] = 32'd0; b2b[g] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 3; g++) rst[g] = 1'b0;
        chk("model 100/7", ref_div(32'd100, 32'd7, 1'b0), {1'b0, 32'd14});
        chk("model -100/7", ref_div(32'hFFFF_FF9C, 32'd7, 1'b1), {1'b0, 32'hFFFF_FFF2});
        chk("model min/-1", ref_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1), {1'b0, 32'h8000_0000});
        chk("model x/0", ref_div(32'd1234, 32'd0, 1'b1), {1'b1, 32'hFFFF_FFFF});
        fork
            directed();
            stream(1, 500);
            stream(2, 500);
        join
        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/div_sequencer.md
# div_sequencer

Sequential launch/capture stage wrapped around the combinational ArrayDivider. It accepts operand pairs over a valid/ready handshake and registers them onto the array inputs. It holds them for a fixed settle window, so the array can be timed as a multicycle path. It then captures the quotient, applies sign correction and divide-by-zero handling, and presents the result over a second valid/ready handshake.

## Interface
- N, 32, operand/quotient width; passed to ArrayDivider.
- SETTLE, 4, cycles operands are held stable before capture (1..15).
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  stage can accept; high only in IDLE.
- in_signed  in  1  treat operands as two's complement.
- Dividend  in  N  dividend.
- Divisor  in  N  divisor.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- Quotient  out  N  registered quotient.
- div_zero  out  1  result came from a zero divisor.

## Operation
- FSM with three states: IDLE, SETTLE, DONE.
- **IDLE:** in_ready=1. When in_valid=1:
  - Latch magnitudes: |Dividend| and |Divisor| when in_signed=1, raw values otherwise.
  - Latch the result sign: Dividend[N-1] XOR Divisor[N-1] when signed, 0 otherwise.
  - Latch zflag = (Divisor==0).
  - Load cnt=SETTLE-1 and go to SETTLE.
- **SETTLE:** operand registers drive ArrayDivider and do not change. cnt decrements each cycle. When cnt==0, capture the result and go to DONE:
  - zflag=1: Quotient = all ones. The array output is ignored.
  - neg=1: Quotient = two's complement of the array output.
  - otherwise: Quotient = array output.
  - div_zero = zflag.
- **DONE:** out_valid=1, and Quotient/div_zero hold stable. On out_ready=1, go to IDLE.
- No input is accepted while busy. There is no overlap and no result buffering beyond one entry.
- Width rules:
  - Magnitude of the most negative value (0x8000_0000 at N=32) is 0x8000_0000, read as unsigned. The array handles it without overflow.
  - Signed 0x8000_0000 / 0xFFFF_FFFF yields 0x8000_0000 (wraps). No flag is raised.
- Reset (synchronous) from any state: state=IDLE, cnt=0, operand registers=0, Quotient=0, div_zero=0, out_valid=0, in_ready=1 on the cycle after reset deasserts. A transaction in flight is discarded.
- in_valid while in_ready=0 has no effect. The upstream block must hold its data.

## Timing
- Accept edge T (in_valid & in_ready).
- Operands reach the array at T+1.
- Capture edge is T+SETTLE. out_valid rises in the cycle after the capture edge (latency SETTLE+1 cycles from accept to out_valid).
- With out_ready held high, the handshake completes on the first DONE cycle. in_ready returns the following cycle.
- Minimum accept-to-accept spacing is SETTLE+2 cycles.
- in_ready and out_valid are registered-state decodes with no combinational path from in_valid/out_ready.
- The ArrayDivider path is constrained as a SETTLE-cycle multicycle path from the operand registers to the quotient capture register.
- SETTLE=1: a single SETTLE cycle, capture on the next edge.

## Structure
- Shared package `div_pkg`:
  - state encoding constants IDLE=2'd0, SETTLE=2'd1, DONE=2'd2
  - default N and SETTLE values
  - a function abs_n(value, signed_en) returning the magnitude
- One sub-module instance: ArrayDivider #(N), driven only from the operand registers.
- Sign negation and zero handling are done in this block and not pushed into the array.

## Test plan
- Unsigned 100 / 7, SETTLE=4, out_ready=1: Quotient=14, div_zero=0, out_valid exactly 5 cycles after the accept edge.
- Signed -100 (0xFFFF_FF9C) / 7: Quotient=0xFFFF_FFF2 (-14). Signed 0x8000_0000 / 0xFFFF_FFFF: Quotient=0x8000_0000.
- 1234 / 0: Quotient=0xFFFF_FFFF, div_zero=1. Next transaction 10/5 gives div_zero=0, Quotient=2.
- Backpressure: out_ready low for 6 cycles. out_valid and Quotient stay stable, in_ready stays 0, and a second in_valid is ignored until the result handshake completes.
- Reset asserted mid-SETTLE: next cycle out_valid=0, Quotient=0, in_ready=1. The following 9/3 returns 3.
- Back-to-back random stream (1000 pairs, both signedness modes, SETTLE=1 and 15): results match a reference model, with accept spacing exactly SETTLE+2 when out_ready=1.
